// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters, registered sync/blanking decode,
// line/frame strobes, a frame counter with sticky wrap flag and an optional sync delay pipe.
module vga_timing_gen #(
    parameter int H_DISPLAY  = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_DISPLAY  = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter int SYNC_POL   = 0,
    parameter int SYNC_DELAY = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [9:0] hpos,
    output logic [9:0] vpos,
    output logic       display_on,
    output logic       hsync,
    output logic       vsync,
    output logic       line_start,
    output logic       frame_start,
    output logic [9:0] frame,
    output logic       frame_wrap,
    output logic       hsync_d,
    output logic       vsync_d,
    output logic       display_on_d
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS      = 10'(H_DISPLAY);
    localparam logic [9:0] V_VIS      = 10'(V_DISPLAY);
    localparam logic [9:0] HS_FIRST   = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_LAST    = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST   = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_LAST    = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);
    localparam logic [9:0] V_PRE_SYNC = 10'(V_DISPLAY + V_FRONT - 1);
    localparam logic       SYNC_ACT   = (SYNC_POL != 0);

    logic [9:0] hpos_q, hpos_d;
    logic [9:0] vpos_q, vpos_d;
    logic [9:0] frame_q, frame_d;
    logic       frame_wrap_q, frame_wrap_d;
    logic       de_q, de_d;
    logic       hs_q, hs_d;
    logic       vs_q, vs_d;
    logic       line_start_q, line_start_d;
    logic       frame_start_q, frame_start_d;
    logic       h_wrap;
    logic       frame_inc;

    assign h_wrap    = (hpos_q == H_LAST);
    assign frame_inc = h_wrap && (vpos_q == V_PRE_SYNC);

    // Decode is taken from the next counter values so every flag lands in the
    // same cycle as the hpos/vpos it describes.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        hpos_d = h_wrap ? 10'd0 : hpos_q + 10'd1;
        vpos_d = vpos_q;
        if (h_wrap) begin
            vpos_d = (vpos_q == V_LAST) ? 10'd0 : vpos_q + 10'd1;
        end

        frame_d      = frame_inc ? frame_q + 10'd1 : frame_q;
        frame_wrap_d = frame_wrap_q | (frame_inc && (frame_q == 10'h3FF));

        de_d          = (hpos_d < H_VIS) && (vpos_d < V_VIS);
        hs_d          = ((hpos_d >= HS_FIRST) && (hpos_d <= HS_LAST)) ? SYNC_ACT : ~SYNC_ACT;
        vs_d          = ((vpos_d >= VS_FIRST) && (vpos_d <= VS_LAST)) ? SYNC_ACT : ~SYNC_ACT;
        line_start_d  = (hpos_d == 10'd0);
        frame_start_d = (hpos_d == 10'd0) && (vpos_d == 10'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hpos_q        <= '0;
            vpos_q        <= '0;
            frame_q       <= '0;
            frame_wrap_q  <= 1'b0;
            de_q          <= 1'b1;
            hs_q          <= ~SYNC_ACT;
            vs_q          <= ~SYNC_ACT;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            hpos_q        <= hpos_d;
            vpos_q        <= vpos_d;
            frame_q       <= frame_d;
            frame_wrap_q  <= frame_wrap_d;
            de_q          <= de_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign hpos        = hpos_q;
    assign vpos        = vpos_q;
    assign display_on  = de_q;
    assign hsync       = hs_q;
    assign vsync       = vs_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign frame       = frame_q;
    assign frame_wrap  = frame_wrap_q;

    generate
        if (SYNC_DELAY == 0) begin : g_no_delay
            assign hsync_d      = hs_q;
            assign vsync_d      = vs_q;
            assign display_on_d = de_q;
        end else begin : g_delay
            logic [SYNC_DELAY-1:0] hs_pipe_q;
            logic [SYNC_DELAY-1:0] vs_pipe_q;
            logic [SYNC_DELAY-1:0] de_pipe_q;

            // Stages reset to blanked/inactive so nothing visible leaks out before the pipe fills.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    hs_pipe_q <= {SYNC_DELAY{~SYNC_ACT}};
                    vs_pipe_q <= {SYNC_DELAY{~SYNC_ACT}};
                    de_pipe_q <= '0;
                end else begin
                    hs_pipe_q[0] <= hs_q;
                    vs_pipe_q[0] <= vs_q;
                    de_pipe_q[0] <= de_q;
                    for (int i = 1; i < SYNC_DELAY; i++) begin
                        hs_pipe_q[i] <= hs_pipe_q[i-1];
                        vs_pipe_q[i] <= vs_pipe_q[i-1];
                        de_pipe_q[i] <= de_pipe_q[i-1];
                    end
                end
            end

            assign hsync_d      = hs_pipe_q[SYNC_DELAY-1];
            assign vsync_d      = vs_pipe_q[SYNC_DELAY-1];
            assign display_on_d = de_pipe_q[SYNC_DELAY-1];
        end
    endgenerate

endmodule
